dw_bsr_chain: RTL and testbench

//   Parametrised boundary-scan register of WIDTH bidirectional cells. It

---
 rtl/dw_bsr_chain.sv | 134 +++++++++++++
 tb/tb_dw_bsr_chain.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dw_bsr_chain.sv
// -----------------------------------------------------------------------------
// dw_bsr_chain
//   Multi-cell boundary-scan register segment (BC_8-style bidirectional cells)
//   placed between the core and the pad ring. It has one shift/capture
//   register (r_sr) and one update register (r_upd). All TAP strobes are
//   synchronous enables on the single clock clk.
//
// Parameters
//   WIDTH    number of cells (1..256); cell 0 drives so
//   CAP_SEL  capture source: 0 = pin_input, 1 = output_data
//   UPD_RST  reset value of every update-register bit (0 or 1)
//
// Ports
//   clk          rising-edge clock for all state
//   rst          asynchronous active-high reset
//   capture_en   enables capture (shift_dr=0) or shift (shift_dr=1)
//   shift_dr     selects shift over capture
//   update_en    loads (toggle=0) or inverts (toggle=1) the update register
//   toggle       EXTEST toggle select
//   mode         00 normal, 01 extest, 10 intest, 11 clamp
//   si           serial scan in, enters cell WIDTH-1
//   pin_input    values from the pads
//   output_data  core functional outputs
//   ic_input     values to the core (combinational)
//   data_out     values to the pads (combinational)
//   so           serial scan out, always the current sr[0]
// -----------------------------------------------------------------------------
module dw_bsr_chain #(
  parameter int WIDTH   = 8,
  parameter int CAP_SEL = 0,
  parameter int UPD_RST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_en,
  input  logic             shift_dr,
  input  logic             update_en,
  input  logic             toggle,
  input  logic [1:0]       mode,
  input  logic             si,
  input  logic [WIDTH-1:0] pin_input,
  input  logic [WIDTH-1:0] output_data,
  output logic [WIDTH-1:0] ic_input,
  output logic [WIDTH-1:0] data_out,
  output logic             so
);

  localparam logic [WIDTH-1:0] UPD_RST_VAL = (UPD_RST != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_upd;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_cap_src;

  // Next shift value: every cell takes its upper neighbour, si enters the top.
  // Written as a loop so WIDTH=1 needs no empty slice.
  always_comb begin
    w_shift_next = r_sr;
    for (int i = 0; i < WIDTH - 1; i++) begin
      w_shift_next[i] = r_sr[i+1];
    end
    w_shift_next[WIDTH-1] = si;
  end

  // Capture source selection.
  always_comb begin
    if (CAP_SEL != 0) begin
      w_cap_src = output_data;
    end else begin
      w_cap_src = pin_input;
    end
  end

  // Shift/capture register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= {WIDTH{1'b0}};
    end else if (capture_en) begin
      if (shift_dr) begin
        r_sr <= w_shift_next;
      end else begin
        r_sr <= w_cap_src;
      end
    end
  end

  // Update register. It samples r_sr before the same edge, so an update
  // coinciding with a shift latches the pre-shift contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upd <= UPD_RST_VAL;
    end else if (update_en) begin
      if (toggle) begin
        r_upd <= ~r_upd;
      end else begin
        r_upd <= r_sr;
      end
    end
  end

  // Pin/core muxing by mode; purely combinational so a mode change is immediate.
  always_comb begin
    data_out = output_data;
    ic_input = pin_input;
    case (mode)
      2'b00: begin
        data_out = output_data;
        ic_input = pin_input;
      end
      2'b01: begin
        data_out = r_upd;
        ic_input = pin_input;
      end
      2'b10: begin
        data_out = output_data;
        ic_input = r_upd;
      end
      2'b11: begin
        data_out = r_upd;
        ic_input = r_upd;
      end
      default: begin
        data_out = output_data;
        ic_input = pin_input;
      end
    endcase
  end

  // Scan out is cell 0; cleared with r_sr on reset.
  always_comb begin
    so = r_sr[0];
  end

endmodule

// File: tb/tb_dw_bsr_chain.sv
// -----------------------------------------------------------------------------
// tb_dw_bsr_chain
//   Self-checking bench for dw_bsr_chain (WIDTH=8, CAP_SEL=0, UPD_RST=0).
//   Expected scan-out bits come from a small shift model and flow through a
//   queue; the mode mux is checked from a vector table.
// -----------------------------------------------------------------------------
module tb_dw_bsr_chain;

  logic       clk;
  logic       rst;
  logic       capture_en;
  logic       shift_dr;
  logic       update_en;
  logic       toggle;
  logic [1:0] mode;
  logic       si;
  logic [7:0] pin_input;
  logic [7:0] output_data;
  logic [7:0] ic_input;
  logic [7:0] data_out;
  logic       so;

  int n_checks;
  int n_err;

  logic [7:0] m_sr;
  logic       q_so[$];

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] pin;
    logic [7:0] od;
    logic [7:0] exp_ic;
    logic [7:0] exp_do;
  } vec_t;

  vec_t vecs[8];

  dw_bsr_chain #(
    .WIDTH  (8),
    .CAP_SEL(0),
    .UPD_RST(0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .capture_en (capture_en),
    .shift_dr   (shift_dr),
    .update_en  (update_en),
    .toggle     (toggle),
    .mode       (mode),
    .si         (si),
    .pin_input  (pin_input),
    .output_data(output_data),
    .ic_input   (ic_input),
    .data_out   (data_out),
    .so         (so)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Capture pin_input into sr.
  task automatic do_capture(input logic [7:0] pins);
    pin_input  = pins;
    capture_en = 1'b1;
    shift_dr   = 1'b0;
    m_sr       = pins;
    tick();
    capture_en = 1'b0;
  endtask

  // One shift; optionally with a simultaneous plain update. The model's new
  // sr[0] is queued at drive time and compared against so after the edge.
  task automatic do_shift(input logic b, input logic upd);
    m_sr = {b, m_sr[7:1]};
    q_so.push_back(m_sr[0]);
    si         = b;
    capture_en = 1'b1;
    shift_dr   = 1'b1;
    update_en  = upd;
    toggle     = 1'b0;
    tick();
    capture_en = 1'b0;
    update_en  = 1'b0;
    check("so_shift", {7'd0, so}, {7'd0, q_so.pop_front()});
  endtask

  task automatic shift_byte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) begin
      do_shift(v[k], 1'b0);
    end
  endtask

  task automatic pulse_update(input logic tg);
    update_en = 1'b1;
    toggle    = tg;
    tick();
    update_en = 1'b0;
    toggle    = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_err       = 0;
    rst         = 1'b0;
    capture_en  = 1'b0;
    shift_dr    = 1'b0;
    update_en   = 1'b0;
    toggle      = 1'b0;
    mode        = 2'b01;
    si          = 1'b0;
    pin_input   = 8'h00;
    output_data = 8'h00;
    m_sr        = 8'h00;

    vecs[0] = '{2'b10, 8'h00, 8'hFF, 8'h81, 8'hFF};
    vecs[1] = '{2'b11, 8'h00, 8'hFF, 8'h81, 8'h81};
    vecs[2] = '{2'b00, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[3] = '{2'b01, 8'h00, 8'hFF, 8'h00, 8'h81};
    vecs[4] = '{2'b00, 8'h3C, 8'hC3, 8'h3C, 8'hC3};
    vecs[5] = '{2'b01, 8'h3C, 8'hC3, 8'h3C, 8'h81};
    vecs[6] = '{2'b10, 8'h3C, 8'hC3, 8'h81, 8'hC3};
    vecs[7] = '{2'b11, 8'h3C, 8'hC3, 8'h81, 8'h81};

    // 1: asynchronous reset, checked before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("rst_data_out", data_out, 8'h00);
    check("rst_so", {7'd0, so}, 8'h00);
    tick();
    tick();
    rst = 1'b0;

    // 2: capture A5 (output_data differs so the source mux matters), shift out.
    output_data = 8'h5A;
    do_capture(8'hA5);
    check("cap_so", {7'd0, so}, 8'h01);
    for (int k = 0; k < 8; k++) begin
      do_shift(1'b0, 1'b0);
    end
    check("sr_empty_model", m_sr, 8'h00);

    // 3: shift in 3C, update, extest drives it on the pads.
    output_data = 8'h00;
    pin_input   = 8'h00;
    shift_byte(8'h3C);
    check("pre_update_do", data_out, 8'h00);
    pulse_update(1'b0);
    check("update_do", data_out, 8'h3C);
    pin_input = 8'h5A;
    #1;
    check("extest_ic_a", ic_input, 8'h5A);
    pin_input = 8'h96;
    #1;
    check("extest_ic_b", ic_input, 8'h96);

    // 4: toggle from 0F; sr must stay 0F, shown by a final plain load.
    shift_byte(8'h0F);
    pulse_update(1'b0);
    check("tog_start", data_out, 8'h0F);
    pulse_update(1'b1);
    check("tog_1", data_out, 8'hF0);
    pulse_update(1'b1);
    check("tog_2", data_out, 8'h0F);
    pulse_update(1'b1);
    check("tog_3", data_out, 8'hF0);
    check("tog_so", {7'd0, so}, 8'h01);
    pulse_update(1'b0);
    check("tog_sr_kept", data_out, 8'h0F);

    // 5: mode table with upd = 81.
    shift_byte(8'h81);
    pulse_update(1'b0);
    for (int v = 0; v < 8; v++) begin
      mode        = vecs[v].mode;
      pin_input   = vecs[v].pin;
      output_data = vecs[v].od;
      #1;
      check($sformatf("mode%0d_ic", v), ic_input, vecs[v].exp_ic);
      check($sformatf("mode%0d_do", v), data_out, vecs[v].exp_do);
    end

    // 6a: update with a shift on the same edge latches the pre-shift sr.
    mode        = 2'b01;
    pin_input   = 8'h00;
    output_data = 8'h00;
    shift_byte(8'h66);
    do_shift(1'b1, 1'b1);
    check("same_edge_upd", data_out, 8'h66);
    pulse_update(1'b0);
    check("same_edge_sr", data_out, 8'hB3);

    // 6b: reset mid-shift, held across an edge with shift still requested.
    do_shift(1'b1, 1'b0);
    do_shift(1'b1, 1'b0);
    capture_en = 1'b1;
    shift_dr   = 1'b1;
    si         = 1'b1;
    rst        = 1'b1;
    #1;
    check("midrst_do", data_out, 8'h00);
    check("midrst_so", {7'd0, so}, 8'h00);
    tick();
    check("midrst_hold_so", {7'd0, so}, 8'h00);
    capture_en = 1'b0;
    shift_dr   = 1'b0;
    si         = 1'b0;
    rst        = 1'b0;
    m_sr       = 8'h00;
    q_so.delete();
    tick();
    check("post_rst_do", data_out, 8'h00);
    shift_byte(8'h00);
    pulse_update(1'b0);
    check("post_rst_sr", data_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
